// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel round-robin arbiter serialising requests onto an 8-bit, 1-cycle-latency memory bus; define MEM_ARB_STATS_EN for per-channel grant counters
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     io_buffer_full,
    input  logic                     flush_in,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH-1:0]          req_write,
    input  logic [2*N_CH-1:0]        req_size,
    input  logic [N_CH-1:0]          req_signed,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_wdata,
    output logic [N_CH-1:0]          req_ready,
    output logic [N_CH-1:0]          resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    output logic                     busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [N_CH*32-1:0]       stat_grants
`endif
);
    localparam int NB = DATA_W / 8;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t              r_state, w_state_nx;
    logic [CW-1:0]       r_ptr, r_g, w_gnt_idx;
    logic                r_signed, r_io;
    logic [ADDR_W-1:0]   r_addr, r_mem_a, w_mem_a, w_cur_addr, w_g_addr;
    logic [DATA_W-1:0]   r_wdata, r_data, w_data_nx, w_cap, w_mask, w_g_wdata;
    logic [2:0]          r_k, r_idx, w_idx_nx, w_g_k;
    logic [7:0]          r_mem_dout, w_mem_dout;
    logic [1:0]          w_g_size;
    logic [N_CH-1:0]     w_ready, w_resp;
    logic                w_any, w_grant, w_idle, w_mem_wr, w_g_write, w_g_io, w_sbit;
    int                  w_d, w_best;

    // Round-robin pick: the valid channel closest after the pointer wins
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = r_ptr;
        w_best    = N_CH;
        w_d       = 0;
        for (int c = 0; c < N_CH; c++) begin
            w_d = c - int'(r_ptr) - 1;
            if (w_d < 0) w_d = w_d + N_CH;
            if (req_valid[c] && w_d < w_best) begin
                w_best    = w_d;
                w_gnt_idx = CW'(c);
                w_any     = 1'b1;
            end
        end
    end

    assign w_g_size   = req_size[w_gnt_idx*2 +: 2];
    assign w_g_addr   = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_g_wdata  = req_wdata[w_gnt_idx*DATA_W +: DATA_W];
    assign w_g_write  = req_write[w_gnt_idx];
    assign w_g_io     = w_g_addr[17:16] == 2'b11;
    assign w_g_k      = (w_g_size == 2'b00) ? 3'd1 : (w_g_size == 2'b01) ? ((NB < 2) ? 3'(NB) : 3'd2) : 3'(NB);
    assign w_cur_addr = r_addr + ADDR_W'(r_idx);

    // Read data with the byte arriving this cycle merged in at its slot
    always_comb begin
        w_cap = r_data;
        w_cap[8*(r_idx-3'd1) +: 8] = mem_din;
    end

    // Byte sequencing, completion and grant; a completing cycle may also grant
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_data_nx  = r_data;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_mem_wr   = 1'b0;
        w_ready    = '0;
        w_resp     = '0;
        w_grant    = 1'b0;
        w_idle     = 1'b0;
        if (rst_in && rdy_in) begin
            case (r_state)
                RD: begin
                    if (flush_in && !r_io) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_data_nx = w_cap;
                        if (r_idx == r_k) begin
                            w_resp[r_g] = 1'b1;
                            w_state_nx  = IDLE;
                            w_idle      = 1'b1;
                        end else begin
                            w_mem_a  = w_cur_addr;
                            w_idx_nx = r_idx + 3'd1;
                        end
                    end
                end
                WR: begin
                    if (r_idx == r_k) begin
                        w_resp[r_g] = 1'b1;
                        w_state_nx  = IDLE;
                        w_idle      = 1'b1;
                    end else begin
                        w_mem_a = w_cur_addr;
                        if (!(r_io && io_buffer_full)) begin
                            w_mem_wr   = 1'b1;
                            w_mem_dout = r_wdata[8*r_idx +: 8];
                            w_idx_nx   = r_idx + 3'd1;
                        end
                    end
                end
                default: w_idle = 1'b1;
            endcase
            if (w_idle && w_any && !flush_in) begin
                w_grant            = 1'b1;
                w_ready[w_gnt_idx] = 1'b1;
                w_mem_a            = w_g_addr;
                w_data_nx          = '0;
                w_state_nx         = w_g_write ? WR : RD;
                w_idx_nx           = 3'd1;
                if (w_g_write && w_g_io && io_buffer_full) begin
                    w_idx_nx = 3'd0;
                end else if (w_g_write) begin
                    w_mem_wr   = 1'b1;
                    w_mem_dout = w_g_wdata[7:0];
                end
            end
        end
    end

    // State, pointer and latched request; everything holds while paused
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_ptr      <= CW'(N_CH - 1);
            r_g        <= '0;
            r_signed   <= 1'b0;
            r_io       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_k        <= '0;
            r_idx      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
        end else if (rdy_in) begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_data     <= w_data_nx;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            if (w_grant) begin
                r_ptr    <= w_gnt_idx;
                r_g      <= w_gnt_idx;
                r_signed <= req_signed[w_gnt_idx];
                r_io     <= w_g_io;
                r_addr   <= w_g_addr;
                r_wdata  <= w_g_wdata;
                r_k      <= w_g_k;
            end
        end
    end

    assign w_mask     = ~({DATA_W{1'b1}} << (8*r_k));
    assign w_sbit     = w_cap[8*r_k-1];
    assign resp_data  = (r_state == RD && |w_resp) ? ((w_cap & w_mask) | ({DATA_W{r_signed & w_sbit}} & ~w_mask)) : '0;
    assign req_ready  = w_ready;
    assign resp_valid = w_resp;
    assign mem_a      = w_mem_a;
    assign mem_dout   = w_mem_dout;
    assign mem_wr     = w_mem_wr;
    assign busy       = r_state != IDLE;

`ifdef MEM_ARB_STATS_EN
    logic [N_CH*32-1:0] r_stat;

    // Saturating per-channel grant counters
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_stat <= '0;
        end else if (rdy_in) begin
            for (int c = 0; c < N_CH; c++)
                if (w_ready[c] && r_stat[c*32 +: 32] != 32'hFFFF_FFFF)
                    r_stat[c*32 +: 32] <= r_stat[c*32 +: 32] + 32'd1;
        end
    end

    assign stat_grants = r_stat;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a 1-cycle-latency RAM model
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int N_CH = 2;

    typedef struct {int ch; logic [31:0] d; int lat;} exp_t;
    typedef struct {int cyc; int ch;} gnt_t;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              rdy_in = 1'b1;
    logic              io_buffer_full = 1'b0;
    logic              flush_in = 1'b0;
    logic [N_CH-1:0]   req_valid = '0;
    logic [N_CH-1:0]   req_write = '0;
    logic [2*N_CH-1:0] req_size = '0;
    logic [N_CH-1:0]   req_signed = '0;
    logic [N_CH*32-1:0] req_addr = '0;
    logic [N_CH*32-1:0] req_wdata = '0;
    logic [N_CH-1:0]   req_ready, resp_valid;
    logic [31:0]       resp_data, mem_a;
    logic [7:0]        mem_din = 8'h00;
    logic [7:0]        mem_dout;
    logic              mem_wr, busy;
`ifdef MEM_ARB_STATS_EN
    logic [N_CH*32-1:0] stat_grants;
`endif

    mem_arbiter #(.N_CH(N_CH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
        .flush_in(flush_in), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
`ifdef MEM_ARB_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    always #5 clk_in = ~clk_in;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          gcyc [N_CH];
    exp_t        sb [$];
    gnt_t        gq [$];
    int          rq [$];
    logic [39:0] wlog [$];
    logic [31:0] atrace [int];
    logic        wtrace [int];
    logic [7:0]  ram [logic [31:0]];
    exp_t        e;
    logic [N_CH-1:0] oh;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : (a[7:0] ^ 8'hA5);
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) mem_din <= ram_rd(mem_a);

    always @(negedge clk_in) begin
        atrace[cyc] = mem_a;
        wtrace[cyc] = mem_wr;
        if (mem_wr) wlog.push_back({mem_a, mem_dout});
        if (req_ready != '0) begin
            check("gnt_onehot", 64'($onehot(req_ready)), 1);
            for (int c = 0; c < N_CH; c++)
                if (req_ready[c]) begin
                    gcyc[c] = cyc;
                    gq.push_back('{cyc, c});
                end
        end
        if (resp_valid != '0) begin
            rq.push_back(cyc);
            if (sb.size() == 0) begin
                check("resp_unexpected", resp_valid, 0);
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e.ch] = 1'b1;
                check("resp_ch", resp_valid, oh);
                check("resp_data", resp_data, e.d);
                check("resp_lat", cyc - gcyc[e.ch], e.lat);
            end
        end
    end

    task automatic wait_grant(input int ch, output int g);
        g = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (req_ready[ch]) begin
                g = cyc;
                return;
            end
        end
        check("grant_timeout", 0, 1);
    endtask

    task automatic do_req(input int ch, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, output int g);
        @(posedge clk_in); #1;
        req_write[ch] = wr;
        req_size[ch*2 +: 2] = sz;
        req_signed[ch] = sg;
        req_addr[ch*32 +: 32] = a;
        req_wdata[ch*32 +: 32] = wd;
        req_valid[ch] = 1'b1;
        wait_grant(ch, g);
        @(posedge clk_in); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clk_in); #1;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, b, rb;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h7] = 8'h80;
        ram[32'h40] = 8'h34; ram[32'h41] = 8'hC2;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", req_ready, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_rdata", resp_data, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_dout", mem_dout, 0);
        check("rst_busy", busy, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        // Both channels contending with byte reads: 0,1,0,1 back to back
        b = gq.size();
        rb = rq.size();
        @(posedge clk_in); #1;
        req_addr = {32'h20, 32'h10};
        req_size = '0;
        req_valid = 2'b11;
        sb.push_back('{0, 32'hB5, 1});
        sb.push_back('{1, 32'h85, 1});
        sb.push_back('{0, 32'hB5, 1});
        sb.push_back('{1, 32'h85, 1});
        for (int i = 0; i < 40 && gq.size() < b + 4; i++) begin
            @(negedge clk_in); #1;
        end
        @(posedge clk_in); #1;
        req_valid = '0;
        drain();
        if (gq.size() >= b + 4 && rq.size() >= rb + 3) begin
            for (int i = 0; i < 4; i++) check("alt_ch", gq[b+i].ch, i % 2);
            for (int i = 0; i < 3; i++) check("b2b_grant", gq[b+i+1].cyc, rq[rb+i]);
        end else begin
            check("alt_grants", gq.size() - b, 4);
        end

        // Ch1 word read, little-endian assembly and address sequence
        sb.push_back('{1, 32'h44332211, 4});
        do_req(1, 0, 2'b10, 0, 32'h100, 0, g);
        check("rd_busy", busy, 1);
        drain();
        for (int i = 0; i < 4; i++) check("rd_addr", atrace[g+i], 32'h100 + i);

        // Byte and half reads, signed and unsigned
        sb.push_back('{0, 32'hFFFFFF80, 1});
        do_req(0, 0, 2'b00, 1, 32'h7, 0, g);
        drain();
        sb.push_back('{0, 32'h00000080, 1});
        do_req(0, 0, 2'b00, 0, 32'h7, 0, g);
        drain();
        sb.push_back('{0, 32'hFFFFC234, 2});
        do_req(0, 0, 2'b01, 1, 32'h40, 0, g);
        drain();
        sb.push_back('{1, 32'h0000C234, 2});
        do_req(1, 0, 2'b01, 0, 32'h40, 0, g);
        drain();

        // Word read wrapping past the top of the address space; size 11 acts as word
        sb.push_back('{0, 32'hA4A55A5B, 4});
        do_req(0, 0, 2'b11, 1, 32'hFFFFFFFE, 0, g);
        drain();
        check("wrap_addr", atrace[g+2], 32'h0);

        // IO half write stalled by a full buffer for three cycles
        wlog.delete();
        io_buffer_full = 1'b1;
        sb.push_back('{1, 32'h0, 5});
        do_req(1, 1, 2'b01, 0, 32'h30000, 32'h0000BEEF, g);
        repeat (2) @(posedge clk_in);
        #1;
        io_buffer_full = 1'b0;
        drain();
        for (int i = 0; i < 3; i++) check("io_stall_wr", wtrace[g+i], 0);
        check("io_wr_cnt", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("io_wr0", wlog[0], {32'h30000, 8'hEF});
            check("io_wr1", wlog[1], {32'h30001, 8'hBE});
        end

        // Non-IO write ignores the full buffer
        wlog.delete();
        io_buffer_full = 1'b1;
        sb.push_back('{0, 32'h0, 4});
        do_req(0, 1, 2'b10, 0, 32'h500, 32'hDEADBEEF, g);
        drain();
        io_buffer_full = 1'b0;
        check("wr_cnt", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("wr_b0", wlog[0], {32'h500, 8'hEF});
            check("wr_b3", wlog[3], {32'h503, 8'hDE});
        end

        // Flush aborts a RAM read; pending ch1 granted right after
        @(posedge clk_in); #1;
        req_write[0] = 1'b0; req_size[1:0] = 2'b10; req_addr[31:0] = 32'h200; req_valid[0] = 1'b1;
        wait_grant(0, g);
        @(posedge clk_in); #1;
        req_valid[0] = 1'b0;
        req_write[1] = 1'b0; req_size[3:2] = 2'b00; req_signed[1] = 1'b0; req_addr[63:32] = 32'h21;
        req_valid[1] = 1'b1;
        sb.push_back('{1, 32'h84, 1});
        @(posedge clk_in); #1;
        flush_in = 1'b1;
        @(negedge clk_in);
        check("flush_no_grant", req_ready, 0);
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        @(negedge clk_in);
        check("flush_busy", busy, 0);
        check("flush_next_grant", req_ready, 2'b10);
        @(posedge clk_in); #1;
        req_valid[1] = 1'b0;
        drain();

        // IO read survives a flush
        sb.push_back('{0, 32'hB6B7B4B5, 4});
        do_req(0, 0, 2'b10, 0, 32'h30010, 0, g);
        @(posedge clk_in); #1;
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        drain();

        // Five-cycle pause mid read, with a flush during the pause
        sb.push_back('{1, 32'h44332211, 9});
        do_req(1, 0, 2'b10, 0, 32'h100, 0, g);
        @(posedge clk_in); #1;
        rdy_in = 1'b0;
        @(posedge clk_in); #1;
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rdy_in = 1'b1;
        drain();
        for (int i = 2; i < 7; i++) check("pause_addr", atrace[g+i], 32'h101);

        // Reset mid-transaction discards it silently
        @(posedge clk_in); #1;
        req_write[0] = 1'b0; req_size[1:0] = 2'b10; req_addr[31:0] = 32'h100; req_valid[0] = 1'b1;
        wait_grant(0, g);
        @(posedge clk_in); #1;
        req_valid[0] = 1'b0;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mem_a", mem_a, 0);
        repeat (6) @(negedge clk_in);
        check("rst_mid_resp", rq.size() > 0 ? rq[rq.size()-1] >= g : 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the single-requestor load/store memory port: an N-channel arbiter in front of the 8-bit, 1-cycle-read-latency RAM/IO bus.
- Serialises multi-byte read/write requests into byte transactions, little-endian.
- Adds round-robin arbitration, signed/unsigned load extension, speculative-read flush and IO back-pressure.
- Sits between the instruction cache / load-store buffer channels and the top-level mem_* pins.

Parameters:
- N_CH, 2, number of requestor channels (channel 0 = instruction fetch by convention).
- ADDR_W, 32, address width.
- DATA_W, 32, request/response data width; must be 8, 16 or 32.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-low reset
- rdy_in  in  1  low = freeze all state, mem_wr forced 0
- io_buffer_full  in  1  UART buffer full; blocks IO writes
- flush_in  in  1  abort in-flight non-IO reads (mispredict)
- req_valid  in  N_CH  per-channel request; held until req_ready
- req_write  in  N_CH  1 = write
- req_size  in  2*N_CH  00 byte, 01 half, 10 word (11 treated as word)
- req_signed  in  N_CH  sign-extend read result
- req_addr  in  N_CH*ADDR_W  byte address
- req_wdata  in  N_CH*DATA_W  write data, low bytes used
- req_ready  out  N_CH  one-hot, one-cycle grant pulse
- resp_valid  out  N_CH  one-hot, one-cycle completion pulse
- resp_data  out  DATA_W  read result, valid with resp_valid
- mem_din  in  8  RAM/IO read byte
- mem_dout  out  8  write byte
- mem_a  out  ADDR_W  byte address
- mem_wr  out  1  1 = write this cycle
- busy  out  1  transaction in progress

Behaviour:
- Reset (rst_in=0 at posedge): req_ready, resp_valid, resp_data, mem_dout, mem_a, mem_wr, busy all 0. FSM enters IDLE. RR pointer = N_CH-1, so channel 0 wins first. Reset mid-transaction discards it with no response.
- States: IDLE, RD, WR.
- IDLE: if any req_valid and flush_in=0, grant the first valid channel after the pointer (wrapping). Grant cycle:
  - req_ready[g]=1 for one cycle.
  - Request fields are latched.
  - First byte issues in the same cycle: mem_a=addr, and for writes mem_wr=1 with mem_dout=byte0.
  - Pointer updates to g.
- Byte count k = 1/2/4 per req_size, capped at DATA_W/8. Byte i uses address addr+i, wrapping mod 2^ADDR_W. Unaligned addresses are allowed.
- RD:
  - Byte i is issued at cycle t_i; mem_din is captured at t_i+1 into bits [8i+7:8i].
  - The last capture happens k cycles after the grant. resp_valid[g] and resp_data are asserted on that same capture cycle, with data combinationally merged.
  - Unused upper bits are zero, or replicate bit 8k-1 when req_signed=1.
  - The response cycle may also be a new IDLE grant cycle (back-to-back, no bubble).
- WR:
  - One byte per cycle, mem_wr=1.
  - resp_valid[g] is asserted in the cycle after the last byte issues, with resp_data=0.
- IO region (addr[17:16]==2'b11):
  - While io_buffer_full=1, IO write bytes are not issued: mem_wr=0, byte index held.
  - IO reads are never aborted by flush.
- flush_in=1:
  - An in-progress non-IO RD returns to IDLE at the next edge with no resp_valid.
  - WR always completes.
  - No grant occurs in a flush cycle.
- rdy_in=0: FSM, pointer, byte index and captured bytes all hold. mem_wr=0, no capture. The system holds mem_din stable across pause; capture resumes on the first rdy_in=1 cycle.
- Simultaneous flush and rdy_in=0: flush is ignored (the pause wins).
- mem_a holds its last value when idle. mem_wr is 0 whenever no write byte issues.

Optional Feature:
- MEM_ARB_STATS_EN: when defined, adds output stat_grants [N_CH*32].
  - Per-channel grant counter, incremented on each req_ready pulse.
  - Saturates at 0xFFFFFFFF, clears on reset, holds while rdy_in=0.
- When undefined, the port and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Ch1 word read addr 0x100, RAM bytes 0x11,0x22,0x33,0x44:
  - mem_a=0x100..0x103 on consecutive cycles.
  - resp_valid[1] at grant+4 with resp_data=0x44332211.
- Ch0 signed byte read at 0x7, mem_din=0x80 -> resp_data=0xFFFFFF80 at grant+1. The same read unsigned -> 0x00000080.
- Ch0 and ch1 both valid continuously, reads:
  - Grants alternate 0,1,0,1 from reset.
  - Each new grant coincides with the previous resp_valid.
- Half write 0xBEEF to 0x30000 with io_buffer_full=1 for 3 cycles:
  - mem_wr=0 during those cycles.
  - Then 0xEF, 0xBE are written.
  - resp_valid one cycle after the last byte.
- Word read to 0x200, flush_in=1 at grant+2:
  - No resp_valid.
  - busy=0 next cycle.
  - A pending ch1 request is granted the cycle after the flush.
- rdy_in=0 for 5 cycles mid word read:
  - mem_a held, no capture.
  - Response delayed exactly 5 cycles with correct data.
